// File: rtl/glay_kernel_cu_dispatch_scheduler.sv
// Kernel-level cluster dispatch scheduler.
// Accepts a run request, issues staggered one-cycle start pulses to the enabled
// clusters, collects their done indications and reports aggregate done.
// An optional watchdog ends a run that takes too long and flags it.
module glay_kernel_cu_dispatch_scheduler #(
  parameter int NUM_GRAPH_CLUSTERS = 4,
  parameter int STAGGER_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES     = 0,
  parameter int TIMEOUT_W          = 32
) (
  input  logic                                        ap_clk,
  input  logic                                        ap_rst_n,
  input  logic                                        sched_start_in,
  input  logic                                        sched_continue_in,
  input  logic [NUM_GRAPH_CLUSTERS-1:0]               cu_enable_mask_in,
  input  logic [NUM_GRAPH_CLUSTERS-1:0]               cu_done_in,
  output logic [NUM_GRAPH_CLUSTERS-1:0]               cu_start_out,
  output logic [NUM_GRAPH_CLUSTERS-1:0]               cu_busy_out,
  output logic                                        sched_ready_out,
  output logic                                        sched_busy_out,
  output logic                                        sched_done_out,
  output logic                                        sched_timeout_out,
  output logic [$clog2(NUM_GRAPH_CLUSTERS+1)-1:0]     dispatch_count_out
);

  localparam int N     = NUM_GRAPH_CLUSTERS;
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);
  localparam int GAP_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  localparam logic [TIMEOUT_W-1:0] WD_MAX  = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(N);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DISPATCH = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_BUSY     = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]           state_q, state_n;
  logic [N-1:0]         mask_q, mask_n;
  logic [N-1:0]         started_q, started_n;
  logic [N-1:0]         done_q, done_n, done_hit;
  logic [PTR_W-1:0]     ptr_q, ptr_n;
  logic [GAP_W-1:0]     gap_q, gap_n;
  logic [TIMEOUT_W-1:0] wd_q, wd_n;
  logic [CNT_W-1:0]     count_q, count_n;
  logic                 to_q, to_n;
  logic                 ready_n;
  logic [N-1:0]         start_n;
  logic                 all_done;
  logic                 in_run;

  // Lowest set bit of m at index >= from (0 when none).
  function automatic logic [PTR_W-1:0] first_set(input logic [N-1:0] m, input int from);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = PTR_W'(i);
    end
    return r;
  endfunction

  // True when m has any set bit strictly above position p.
  function automatic logic any_above(input logic [N-1:0] m, input logic [PTR_W-1:0] p);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m[i] && (i > int'(p))) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PTR_W-1:0] p);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (i == int'(p));
    return v;
  endfunction

  // Next-state decode: run sequencing, done collection and watchdog.
  always_comb begin
    state_n   = state_q;
    mask_n    = mask_q;
    started_n = started_q;
    ptr_n     = ptr_q;
    gap_n     = gap_q;
    wd_n      = wd_q;
    count_n   = count_q;
    to_n      = to_q;
    ready_n   = 1'b0;
    done_hit  = done_q | (cu_done_in & started_q & mask_q);
    done_n    = (state_q == ST_IDLE) ? done_q : done_hit;
    all_done  = (done_hit == mask_q);
    in_run    = (state_q == ST_DISPATCH) || (state_q == ST_GAP) || (state_q == ST_BUSY);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sched_start_in) begin
          mask_n    = cu_enable_mask_in;
          started_n = '0;
          done_n    = '0;
          count_n   = '0;
          to_n      = 1'b0;
          wd_n      = TIMEOUT_W'(1);
          ready_n   = 1'b1;
          ptr_n     = first_set(cu_enable_mask_in, 0);
          state_n   = (cu_enable_mask_in == '0) ? ST_DONE : ST_DISPATCH;
        end else if ((state_q == ST_DONE) && sched_continue_in) begin
          state_n = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        // The pulse for ptr is on the wire this cycle; it counts as started from now on.
        started_n = started_q | onehot(ptr_q);
        if (count_q != CNT_MAX) count_n = count_q + CNT_W'(1);
        if (!any_above(mask_q, ptr_q)) begin
          state_n = ST_BUSY;
        end else if (STAGGER_CYCLES > 0) begin
          state_n = ST_GAP;
          gap_n   = GAP_W'(STAGGER_CYCLES - 1);
        end else begin
          ptr_n = first_set(mask_q, int'(ptr_q) + 1);
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_n = ST_DISPATCH;
          ptr_n   = first_set(mask_q, int'(ptr_q) + 1);
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end
      ST_BUSY: begin
        if (all_done) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase

    // A run that completes in the same cycle as the watchdog expiry is a normal completion.
    if ((TIMEOUT_CYCLES > 0) && in_run && !((state_q == ST_BUSY) && all_done)) begin
      if (wd_q != WD_MAX) wd_n = wd_q + TIMEOUT_W'(1);
      if (wd_q >= WD_LAST) begin
        to_n    = 1'b1;
        state_n = ST_DONE;
      end
    end

    start_n = (state_n == ST_DISPATCH) ? onehot(ptr_n) : '0;
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q            <= ST_IDLE;
      mask_q             <= '0;
      started_q          <= '0;
      done_q             <= '0;
      ptr_q              <= '0;
      gap_q              <= '0;
      wd_q               <= '0;
      count_q            <= '0;
      to_q               <= 1'b0;
      cu_start_out       <= '0;
      cu_busy_out        <= '0;
      sched_ready_out    <= 1'b0;
      sched_busy_out     <= 1'b0;
      sched_done_out     <= 1'b0;
    end else begin
      state_q            <= state_n;
      mask_q             <= mask_n;
      started_q          <= started_n;
      done_q             <= done_n;
      ptr_q              <= ptr_n;
      gap_q              <= gap_n;
      wd_q               <= wd_n;
      count_q            <= count_n;
      to_q               <= to_n;
      cu_start_out       <= start_n;
      cu_busy_out        <= started_n & ~done_n;
      sched_ready_out    <= ready_n;
      sched_busy_out     <= (state_n == ST_DISPATCH) || (state_n == ST_GAP) || (state_n == ST_BUSY);
      sched_done_out     <= (state_n == ST_DONE);
    end
  end

  assign sched_timeout_out  = to_q;
  assign dispatch_count_out = count_q;

endmodule

// File: tb/tb_glay_kernel_cu_dispatch_scheduler.sv
// Bench for the cluster dispatch scheduler: a table of runs, randomized runs
// checked against a schedule-level model, and hand-written corner sequences.
module tb_glay_kernel_cu_dispatch_scheduler;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;

  logic       start0, cont0;
  logic [3:0] mask0, done0;
  logic [3:0] cs0, cb0;
  logic       rdy0, bsy0, dn0, to0;
  logic [2:0] cnt0;

  logic       start1, cont1;
  logic [3:0] mask1, done1;
  logic [3:0] cs1, cb1;
  logic       rdy1, bsy1, dn1, to1;
  logic [2:0] cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  glay_kernel_cu_dispatch_scheduler #(
    .NUM_GRAPH_CLUSTERS(4), .STAGGER_CYCLES(2), .TIMEOUT_CYCLES(20), .TIMEOUT_W(32)
  ) u0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .sched_start_in(start0), .sched_continue_in(cont0),
    .cu_enable_mask_in(mask0), .cu_done_in(done0),
    .cu_start_out(cs0), .cu_busy_out(cb0),
    .sched_ready_out(rdy0), .sched_busy_out(bsy0), .sched_done_out(dn0),
    .sched_timeout_out(to0), .dispatch_count_out(cnt0)
  );

  glay_kernel_cu_dispatch_scheduler #(
    .NUM_GRAPH_CLUSTERS(4), .STAGGER_CYCLES(0), .TIMEOUT_CYCLES(0), .TIMEOUT_W(32)
  ) u1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .sched_start_in(start1), .sched_continue_in(cont1),
    .cu_enable_mask_in(mask1), .cu_done_in(done1),
    .cu_start_out(cs1), .cu_busy_out(cb1),
    .sched_ready_out(rdy1), .sched_busy_out(bsy1), .sched_done_out(dn1),
    .sched_timeout_out(to1), .dispatch_count_out(cnt1)
  );

  typedef struct {
    logic [3:0] mask;
    int         d;
    int         cnt;
    int         off;
    bit         to;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // One run on u0 (stagger 2, watchdog 20). Cluster i reports done d_i cycles after its start pulse.
  // Cycle k counts from the accept edge; expectations come from the start schedule
  // (k-th enabled cluster starts at 1 + 3*rank) and the caller's completion offset.
  task automatic run0(input logic [3:0] m, input int d0, input int d1, input int d2, input int d3,
                      input bit with_cont, input int exp_cnt, input int exp_off, input bit exp_to);
    int dl[4];
    int st[4];
    int rank;
    logic [3:0] es, eb, dv;
    dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    rank = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        st[i] = 1 + rank * 3;
        rank++;
      end else begin
        st[i] = -100;
      end
    end
    start0 = 1'b1;
    cont0  = with_cont;
    mask0  = m;
    done0  = '0;
    tick();
    start0 = 1'b0;
    cont0  = 1'b0;
    mask0  = 4'($urandom);
    for (int k = 1; k <= exp_off; k++) begin
      for (int i = 0; i < 4; i++) begin
        es[i] = m[i] && (k == st[i]) && (k < exp_off);
        eb[i] = m[i] && (k >= st[i] + 1) && (k <= st[i] + dl[i]);
      end
      chk("ready", int'(rdy0), int'(k == 1));
      chk("cu_start", int'(cs0), int'(es));
      chk("cu_busy", int'(cb0), int'(eb));
      chk("sched_busy", int'(bsy0), int'(k < exp_off));
      chk("sched_done", int'(dn0), int'(k == exp_off));
      chk("timeout", int'(to0), int'((k == exp_off) && exp_to));
      if (k == exp_off) chk("count", int'(cnt0), exp_cnt);
      for (int i = 0; i < 4; i++) begin
        dv[i] = m[i] ? (k == st[i] + dl[i]) : 1'($urandom_range(0, 1));
      end
      done0 = dv;
      tick();
    end
    done0 = '0;
  endtask

  task automatic do_cont0(input bit exp_to);
    cont0 = 1'b1;
    chk("done_hold", int'(dn0), 1);
    chk("timeout_hold", int'(to0), int'(exp_to));
    tick();
    cont0 = 1'b0;
    chk("idle_done", int'(dn0), 0);
    chk("idle_busy", int'(bsy0), 0);
    chk("idle_start", int'(cs0), 0);
    chk("idle_timeout", int'(to0), int'(exp_to));
  endtask

  initial begin
    int m_r, last, off, cnt;
    bit to_r, in_done, wc;
    int dr[4];
    int rank;

    tbl[0] = '{4'b1111, 10, 4, 20, 1'b1};
    tbl[1] = '{4'b1111,  2, 4, 13, 1'b0};
    tbl[2] = '{4'b0000,  1, 0,  1, 1'b0};
    tbl[3] = '{4'b1111,  9, 4, 20, 1'b0};
    tbl[4] = '{4'b0100,  1, 1,  3, 1'b0};
    tbl[5] = '{4'b1010,  5, 2, 10, 1'b0};
    tbl[6] = '{4'b0001,  3, 1,  5, 1'b0};

    ap_rst_n = 1'b0;
    start0 = 0; cont0 = 0; mask0 = 0; done0 = 0;
    start1 = 0; cont1 = 0; mask1 = 0; done1 = 0;
    tick();
    tick();
    chk("rst_start", int'(cs0), 0);
    chk("rst_busyv", int'(cb0), 0);
    chk("rst_ready", int'(rdy0), 0);
    chk("rst_busy", int'(bsy0), 0);
    chk("rst_done", int'(dn0), 0);
    chk("rst_timeout", int'(to0), 0);
    chk("rst_count", int'(cnt0), 0);
    ap_rst_n = 1'b1;
    tick();

    // Table of runs; odd rows leave the block in DONE so the next start also asserts continue.
    in_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run0(tbl[i].mask, tbl[i].d, tbl[i].d, tbl[i].d, tbl[i].d, in_done,
           tbl[i].cnt, tbl[i].off, tbl[i].to);
      if (i % 2 == 0) begin
        do_cont0(tbl[i].to);
        in_done = 1'b0;
      end else begin
        in_done = 1'b1;
      end
    end
    if (in_done) do_cont0(1'b0);

    // Randomized runs against the schedule model.
    in_done = 1'b0;
    for (int r = 0; r < 40; r++) begin
      m_r = int'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) dr[i] = int'($urandom_range(1, 12));
      rank = 0;
      last = 0;
      cnt  = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_r[i]) begin
          if (1 + rank * 3 + dr[i] > last) last = 1 + rank * 3 + dr[i];
          rank++;
          cnt++;
        end
      end
      if (m_r == 0) begin
        off = 1; to_r = 1'b0;
      end else if (last <= 19) begin
        off = last + 1; to_r = 1'b0;
      end else begin
        off = 20; to_r = 1'b1;
      end
      wc = in_done ? 1'b1 : 1'($urandom_range(0, 1));
      run0(4'(m_r), dr[0], dr[1], dr[2], dr[3], wc, cnt, off, to_r);
      if ($urandom_range(0, 1) == 1) begin
        do_cont0(to_r);
        in_done = 1'b0;
      end else begin
        in_done = 1'b1;
      end
    end
    if (in_done) begin
      cont0 = 1'b1;
      tick();
      cont0 = 1'b0;
    end

    // Done arriving in the same cycle as the start pulse is ignored.
    start0 = 1'b1; mask0 = 4'b0001;
    tick();
    start0 = 1'b0;
    chk("co_start", int'(cs0), 1);
    done0 = 4'b0001;
    tick();
    done0 = 4'b0000;
    chk("co_busyv", int'(cb0), 1);
    chk("co_done_k2", int'(dn0), 0);
    tick();
    chk("co_done_k3", int'(dn0), 0);
    chk("co_busyv_k3", int'(cb0), 1);
    done0 = 4'b0001;
    tick();
    done0 = 4'b0000;
    chk("co_done_k4", int'(dn0), 1);
    chk("co_busyv_k4", int'(cb0), 0);
    do_cont0(1'b0);

    // Back-to-back dispatch with a done from a disabled cluster held high.
    start1 = 1'b1; mask1 = 4'b1010; done1 = 4'b0001;
    tick();
    start1 = 1'b0; mask1 = 4'b1111;
    chk("b2b_ready", int'(rdy1), 1);
    chk("b2b_start1", int'(cs1), 4'b0010);
    tick();
    chk("b2b_start3", int'(cs1), 4'b1000);
    chk("b2b_ready_off", int'(rdy1), 0);
    tick();
    chk("b2b_start_none", int'(cs1), 0);
    chk("b2b_count", int'(cnt1), 2);
    chk("b2b_busyv", int'(cb1), 4'b1010);
    chk("b2b_done_early", int'(dn1), 0);
    done1 = 4'b1011;
    tick();
    done1 = 4'b0000;
    chk("b2b_done", int'(dn1), 1);
    chk("b2b_busy", int'(bsy1), 0);
    chk("b2b_count_end", int'(cnt1), 2);
    chk("b2b_no_timeout", int'(to1), 0);
    cont1 = 1'b1;
    tick();
    cont1 = 1'b0;
    chk("b2b_idle", int'(dn1), 0);

    // Asynchronous reset in the middle of a stagger gap.
    start0 = 1'b1; mask0 = 4'b1111;
    tick();
    start0 = 1'b0;
    tick();
    chk("gap_busy", int'(bsy0), 1);
    chk("gap_count", int'(cnt0), 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bsy0), 0);
    chk("arst_busyv", int'(cb0), 0);
    chk("arst_count", int'(cnt0), 0);
    chk("arst_start", int'(cs0), 0);
    chk("arst_done", int'(dn0), 0);
    tick();
    ap_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_start", int'(cs0), 0);
      chk("post_rst_busy", int'(bsy0), 0);
      chk("post_rst_done", int'(dn0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
